// File: rtl/csa_stream_accumulator.sv
// ============================================================================
// csa_stream_accumulator
// ----------------------------------------------------------------------------
// Streaming multi-operand unsigned adder. Operands arrive over a valid/ready
// handshake and are folded into a redundant (sum, carry) pair by a 3:2
// carry-save stage, one operand per cycle with no carry propagation. When the
// operand flagged "last" is accepted, the redundant pair is resolved by a
// chunked carry-propagate adder, CHUNK bits per cycle over NCHUNK cycles, and
// the result is offered on a valid/ready output port.
//
// Parameters:
//   WIDTH    operand width in bits
//   MAX_OPS  operands per batch that are guaranteed not to overflow
//   CHUNK    bits resolved per cycle by the final adder (must divide ACC_W)
//
// Derived:
//   CNT_W  = $clog2(MAX_OPS)
//   ACC_W  = WIDTH + CNT_W   accumulator / result width
//   NCHUNK = ACC_W / CHUNK   resolve latency in cycles
//
// Ports:
//   clk        in   1         sole clock, rising edge
//   rst_n      in   1         synchronous active-low reset
//   in_valid   in   1         operand valid
//   in_ready   out  1         block can accept an operand
//   in_data    in   WIDTH     unsigned operand
//   in_last    in   1         marks the final operand of a batch
//   out_valid  out  1         result valid
//   out_ready  in   1         consumer accepts the result
//   out_sum    out  ACC_W     resolved batch sum
//   out_count  out  CNT_W+1   operand count of the batch, saturating
//   out_ovf    out  1         overflow flag
//
// Optional feature (macro CSA_OVF_EN):
//   Defined     -> a sticky overflow flag is kept; on overflow out_ovf=1 and
//                  out_sum saturates to all-ones.
//   Not defined -> out_ovf is tied 0 and the sum wraps modulo 2^ACC_W.
// ============================================================================
module csa_stream_accumulator #(
    parameter int WIDTH   = 8,
    parameter int MAX_OPS = 16,
    parameter int CHUNK   = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH+$clog2(MAX_OPS)-1:0] out_sum,
    output logic [$clog2(MAX_OPS):0]        out_count,
    output logic                            out_ovf
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int CNT_W  = $clog2(MAX_OPS);
    localparam int ACC_W  = WIDTH + CNT_W;
    localparam int NCHUNK = ACC_W / CHUNK;
    localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // The chunked adder walks whole chunks; a ragged last chunk is rejected.
    if ((ACC_W % CHUNK) != 0) begin : g_bad_chunk
        $error("csa_stream_accumulator: ACC_W (%0d) is not a multiple of CHUNK (%0d)",
               ACC_W, CHUNK);
    end

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic                 r_in_ready;
    logic [ACC_W-1:0]     r_sum;      // redundant sum vector
    logic [ACC_W-1:0]     r_carry;    // redundant carry vector (already weighted)
    logic [ACC_W-1:0]     r_res;      // resolved result, filled chunk by chunk
    logic [CNT_W:0]       r_cnt;      // operand count, saturating
    logic [K_W-1:0]       r_k;        // chunk index during resolve
    logic                 r_cin;      // carry between resolve chunks

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    state_t               w_state_next;
    logic                 w_out_valid;
    logic                 w_accept;
    logic                 w_out_fire;
    logic [ACC_W-1:0]     w_d;
    logic [ACC_W-1:0]     w_maj;
    logic [ACC_W-1:0]     w_sum_next;
    logic [ACC_W-1:0]     w_carry_next;
    logic [CNT_W:0]       w_cnt_next;
    logic [CHUNK:0]       w_chunk_full;
    logic [CHUNK-1:0]     w_chunk;
    logic                 w_chunk_cout;
    logic                 w_last_chunk;
    logic [ACC_W-1:0]     w_res_next;
    logic                 w_ovf;

    assign w_accept   = in_valid & r_in_ready;
    assign w_out_fire = w_out_valid & out_ready;

    // ------------------------------------------------------------------------
    // 3:2 carry-save stage
    // ------------------------------------------------------------------------
    assign w_d          = ACC_W'(in_data);
    assign w_sum_next   = r_sum ^ r_carry ^ w_d;
    assign w_maj        = (r_sum & r_carry) | (r_sum & w_d) | (r_carry & w_d);
    // The majority MSB falls off the top here; the overflow option watches it.
    assign w_carry_next = w_maj << 1;

    assign w_cnt_next   = (&r_cnt) ? r_cnt : r_cnt + (CNT_W+1)'(1);

    // ------------------------------------------------------------------------
    // Chunked carry-propagate adder
    // ------------------------------------------------------------------------
    // r_sum/r_carry are shifted right by CHUNK every resolve cycle, so the
    // chunk being worked on always sits in the low bits. The result register
    // shifts the same way with each new chunk entering at the top; after
    // NCHUNK cycles chunk k has landed at bits [k*CHUNK +: CHUNK].
    assign w_chunk_full = {1'b0, r_sum[CHUNK-1:0]}
                        + {1'b0, r_carry[CHUNK-1:0]}
                        + {{CHUNK{1'b0}}, r_cin};
    assign w_chunk      = w_chunk_full[CHUNK-1:0];
    assign w_chunk_cout = w_chunk_full[CHUNK];
    assign w_res_next   = ACC_W'({w_chunk, r_res} >> CHUNK);
    assign w_last_chunk = (r_k == K_W'(NCHUNK - 1));

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            // NOTE: every clocked assignment uses <= so all registers sample
            // the same pre-edge values regardless of statement order.
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        w_state_next = r_state;
        w_out_valid  = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept && in_last) begin
                    w_state_next = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                if (w_last_chunk) begin
                    w_state_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_ACCUM;
                end
            end
            default: begin
                w_state_next = ST_ACCUM;
            end
        endcase
    end

    // in_ready is registered so it stays low for the whole reset and rises
    // only on the first clock edge that sees rst_n high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_state_next == ST_ACCUM);
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the whole datapath is reset; it is a handful of flops, and
            // a reset mid-batch must discard every partial value.
            r_sum   <= '0;
            r_carry <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_k     <= '0;
            r_cin   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_sum   <= w_sum_next;
                        r_carry <= w_carry_next;
                        r_cnt   <= w_cnt_next;
                        if (in_last) begin
                            r_k   <= '0;
                            r_cin <= 1'b0;
                        end
                    end
                end
                ST_RESOLVE: begin
                    r_sum   <= r_sum >> CHUNK;
                    r_carry <= r_carry >> CHUNK;
                    r_res   <= w_res_next;
                    r_cin   <= w_chunk_cout;
                    r_k     <= r_k + K_W'(1);
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        r_sum   <= '0;
                        r_carry <= '0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_sum   <= '0;
                    r_carry <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Optional overflow tracking
    // ------------------------------------------------------------------------
`ifdef CSA_OVF_EN
    logic r_ovf;

    // The true total is r_sum + r_carry + (dropped MSBs << ACC_W) + final
    // chunk carry-out << ACC_W. All terms are nonnegative, so any dropped
    // bit or a final carry-out means the sum left the ACC_W range.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept && w_maj[ACC_W-1]) begin
                        r_ovf <= 1'b1;
                    end
                end
                ST_RESOLVE: begin
                    if (w_last_chunk && w_chunk_cout) begin
                        r_ovf <= 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (w_out_fire) begin
                        r_ovf <= 1'b0;
                    end
                end
                default: begin
                    r_ovf <= 1'b0;
                end
            endcase
        end
    end

    assign w_ovf = r_ovf;
`else
    assign w_ovf = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_sum   = w_ovf ? {ACC_W{1'b1}} : r_res;
    assign out_count = r_cnt;
    assign out_ovf   = w_ovf;

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// ============================================================================
// tb_csa_stream_accumulator
// ----------------------------------------------------------------------------
// Directed bench for csa_stream_accumulator at default parameters
// (WIDTH=8, MAX_OPS=16, CHUNK=4 -> ACC_W=12, NCHUNK=3, out_count 5 bits).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ============================================================================
module tb_csa_stream_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic [4:0]  out_count;
    logic        out_ovf;

    int n_checks = 0;
    int n_errors = 0;

    csa_stream_accumulator #(
        .WIDTH   (8),
        .MAX_OPS (16),
        .CHUNK   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand and hold it until it is accepted (bounded wait).
    // in_valid is left high so consecutive calls are back-to-back.
    task automatic send(input logic [7:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_release_ready", 32'(in_ready), 32'd1);

        // ---------------- 3 + 5 + 7, latency ----------------
        send(8'd3, 1'b0);
        send(8'd5, 1'b0);
        send(8'd7, 1'b1);
        idle();
        tick();
        check("lat_t1_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_t2_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_t3_valid", 32'(out_valid), 32'd1);
        check("b357_sum",   32'(out_sum),   32'd15);
        check("b357_count", 32'(out_count), 32'd3);
        check("b357_ovf",   32'(out_ovf),   32'd0);
        tick();
        check("b357_post_valid", 32'(out_valid), 32'd0);
        check("b357_post_ready", 32'(in_ready),  32'd1);

        // ---------------- 16 x 0xFF back-to-back ----------------
        for (int i = 0; i < 16; i++) begin
            check("b16_ready", 32'(in_ready), 32'd1);
            send(8'hFF, (i == 15));
        end
        idle();
        wait_out();
        check("b16_sum",   32'(out_sum),   32'h0FF0);
        check("b16_count", 32'(out_count), 32'd16);
        check("b16_ovf",   32'(out_ovf),   32'd0);
        tick();

        // ---------------- 17 x 0xFF: overflow ----------------
        for (int i = 0; i < 17; i++) begin
            send(8'hFF, (i == 16));
        end
        idle();
        wait_out();
`ifdef CSA_OVF_EN
        check("b17_sum", 32'(out_sum), 32'h0FFF);
        check("b17_ovf", 32'(out_ovf), 32'd1);
`else
        check("b17_sum", 32'(out_sum), 32'h00EF);
        check("b17_ovf", 32'(out_ovf), 32'd0);
`endif
        check("b17_count", 32'(out_count), 32'd17);
        tick();
        send(8'd1, 1'b1);
        idle();
        wait_out();
        check("after_ovf_sum",   32'(out_sum),   32'd1);
        check("after_ovf_count", 32'(out_count), 32'd1);
        check("after_ovf_ovf",   32'(out_ovf),   32'd0);
        tick();

        // ---------------- backpressure: 10 + 20, out_ready low ----------------
        out_ready = 1'b0;
        send(8'd10, 1'b0);
        send(8'd20, 1'b1);
        idle();
        wait_out();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_sum",      32'(out_sum),   32'd30);
            check("bp_count",    32'(out_count), 32'd2);
            check("bp_in_ready", 32'(in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_ready", 32'(in_ready),  32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);

        // ---------------- reset mid-batch ----------------
        send(8'd9, 1'b0);
        send(8'd9, 1'b0);
        idle();
        rst_n = 1'b0;
        tick();
        check("midrst_ready", 32'(in_ready),  32'd0);
        check("midrst_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;
        send(8'd4, 1'b1);
        idle();
        wait_out();
        check("midrst_sum",       32'(out_sum),   32'd4);
        check("midrst_sum_count", 32'(out_count), 32'd1);
        tick();

        // ---------------- reset during RESOLVE ----------------
        send(8'd5, 1'b1);
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("resrst_sum", 32'(out_sum), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("resrst_no_valid", 32'(seen),     32'd0);
        check("resrst_ready",    32'(in_ready), 32'd1);

        // ---------------- single operand 0xAB ----------------
        send(8'hAB, 1'b1);
        idle();
        wait_out();
        check("single_sum",   32'(out_sum),   32'h00AB);
        check("single_count", 32'(out_count), 32'd1);
        tick();

        // ---------------- in_last with in_valid low is ignored ----------------
        in_valid = 1'b0;
        in_last  = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'(8'h30 + i);
            if (out_valid) seen++;
            tick();
        end
        check("idle_last_no_valid", 32'(seen),      32'd0);
        check("idle_last_count",    32'(out_count), 32'd0);
        check("idle_last_ready",    32'(in_ready),  32'd1);
        send(8'd2, 1'b1);
        idle();
        wait_out();
        check("idle_last_sum",       32'(out_sum),   32'd2);
        check("idle_last_sum_count", 32'(out_count), 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
